// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and oversampling constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int OSR_DEF = 16;
  localparam int MID_IDX = OSR_DEF / 2 - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_state_e;

  function automatic int mid_idx(input int osr);
    return osr / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line.
// Resets to 1 so an idle line never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic aresetn,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_async.sv
// Oversampling UART receiver with glitch, framing, break and overflow handling.
// Parity checking is compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_async
  import uart_pkg::*;
#(
  parameter int OSR         = OSR_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] TMID  = TW'(mid_idx(OSR));
  localparam logic [TW-1:0] TLAST = TW'(OSR - 1);

  uart_state_e r_state;
  uart_state_e w_next;

  logic          w_rx_s;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic [7:0]    w_byte;
  logic          w_last_bit;
  logic          w_start_chk;
  logic          w_sample;
  logic          w_shift;
  logic          w_par;
  logic          w_done;
  logic          w_perr;

  logic [7:0] r_data;
  logic       r_ready;
  logic       r_ferr;
  logic       r_ovf;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .aresetn(aresetn),
    .i_d    (rx),
    .o_q    (w_rx_s)
  );

  assign w_byte     = bit8 ? r_shift : {1'b0, r_shift[7:1]};
  assign w_last_bit = (r_bit == (bit8 ? 3'd7 : 3'd6));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (baud_tick && !w_rx_s) w_next = S_START;
      S_START:
        if (w_start_chk) w_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA:
        if (w_shift && w_last_bit) begin
`ifdef UART_RX_PARITY_EN
          w_next = parity_en ? S_PARITY : S_STOP;
`else
          w_next = S_STOP;
`endif
        end
      S_PARITY:
        if (w_sample) w_next = S_STOP;
      S_STOP:
        if (w_sample) w_next = w_rx_s ? S_IDLE : S_BREAK;
      S_BREAK:
        if (baud_tick && w_rx_s) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start_chk = 1'b0;
    w_sample    = 1'b0;
    w_shift     = 1'b0;
    w_par       = 1'b0;
    w_done      = 1'b0;
    if (r_state == S_START)
      w_start_chk = baud_tick && (r_tick == TMID);
    if (r_state == S_DATA || r_state == S_PARITY || r_state == S_STOP)
      w_sample = baud_tick && (r_tick == TLAST);
    w_shift = w_sample && (r_state == S_DATA);
    w_par   = w_sample && (r_state == S_PARITY);
    w_done  = w_sample && (r_state == S_STOP);
  end

  // Counter restarts at every sample point so each bit spans exactly OSR ticks.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else if (baud_tick) begin
      if (r_state == S_IDLE || r_state == S_BREAK ||
          w_start_chk || w_sample)
        r_tick <= '0;
      else
        r_tick <= r_tick + 1'b1;
      if (w_start_chk) begin
        r_bit   <= '0;
        r_shift <= '0;
      end else if (w_shift) begin
        r_bit   <= w_last_bit ? 3'd0 : r_bit + 3'd1;
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_perr_pend;
  logic r_perr;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      r_perr_pend <= 1'b0;
    else if (w_start_chk)
      r_perr_pend <= 1'b0;
    else if (w_par)
      r_perr_pend <= (^w_byte) ^ w_rx_s ^ odd_n_even;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)
      r_perr <= 1'b0;
    else if (w_done && (!r_ready || rx_read))
      r_perr <= r_perr_pend;
  end

  assign w_perr = r_perr;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = &{1'b0, parity_en, odd_n_even, w_par};
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_data  <= '0;
      r_ready <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_done) begin
      if (!r_ready || rx_read) begin
        r_data  <= w_byte;
        r_ready <= 1'b1;
        r_ferr  <= ~w_rx_s;
        r_ovf   <= 1'b0;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (rx_read && r_ready) begin
      r_ready <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign rx_data     = r_data;
  assign rx_ready    = r_ready;
  assign parity_err  = w_perr;
  assign framing_err = r_ferr;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_uart_rx_async.sv
// Directed bench for uart_rx_async at OSR = 16, baud_tick every 4 clocks.
// Parity expectations follow UART_RX_PARITY_EN.
module tb_uart_rx_async;

  localparam int OSR    = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OSR * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  logic       clk;
  logic       aresetn;
  logic       baud_tick;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_async #(
    .OSR        (OSR),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .bit8       (bit8),
    .parity_en  (parity_en),
    .odd_n_even (odd_n_even),
    .rx_read    (rx_read),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .framing_err(framing_err),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    int tcnt;
    tcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      baud_tick = (tcnt % TDIV == 0);
    end
  end

  task automatic wait_bits(input int n);
    repeat (n * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int nb,
                            input logic pen, input logic pb,
                            input logic sb);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < nb; i++) begin
      rx = b[i];
      wait_bits(1);
    end
    if (pen) begin
      rx = pb;
      wait_bits(1);
    end
    rx = sb;
    wait_bits(1);
    rx = 1'b1;
  endtask

  task automatic do_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_data got %h want 00", rx_data);
    end
    checks++;
    if ({rx_ready, parity_err, framing_err, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               {rx_ready, parity_err, framing_err, overflow});
    end
    aresetn = 1'b1;
    wait_bits(1);
  endtask

  task automatic test_8n1();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if (rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL 8n1_data got %h want a5", rx_data);
    end
    checks++;
    if ({rx_ready, parity_err, framing_err, overflow} !== 4'b1000) begin
      errors++;
      $display("FAIL 8n1_flags got %b want 1000",
               {rx_ready, parity_err, framing_err, overflow});
    end
    do_read();
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL 8n1_read got %b want 0", rx_ready);
    end
    wait_bits(1);
  endtask

  task automatic test_parity();
    bit8 = 1'b0;
    parity_en = 1'b1;
    odd_n_even = 1'b0;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rx_data !== 8'h41) begin
      errors++;
      $display("FAIL par_bad_data got %h want 41", rx_data);
    end
    checks++;
    if (parity_err !== PERR_EXP) begin
      errors++;
      $display("FAIL par_bad_err got %b want %b", parity_err, PERR_EXP);
    end
    do_read();
    wait_bits(1);
    odd_n_even = 1'b1;
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({rx_data, parity_err, framing_err} !== {8'h41, 2'b00}) begin
      errors++;
      $display("FAIL par_ok got %h/%b%b want 41/00",
               rx_data, parity_err, framing_err);
    end
    do_read();
    bit8 = 1'b1;
    parity_en = 1'b0;
    odd_n_even = 1'b0;
    wait_bits(1);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (5 * TDIV) @(negedge clk);
    rx = 1'b1;
    wait_bits(2);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ready got %b want 0", rx_ready);
    end
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_data, rx_ready} !== {8'h81, 1'b1}) begin
      errors++;
      $display("FAIL glitch_next got %h/%b want 81/1", rx_data, rx_ready);
    end
    do_read();
    wait_bits(1);
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    wait_bits(30);
    checks++;
    if ({rx_data, rx_ready, framing_err} !== {8'h3C, 2'b11}) begin
      errors++;
      $display("FAIL frm_err got %h/%b%b want 3c/11",
               rx_data, rx_ready, framing_err);
    end
    rx = 1'b1;
    wait_bits(2);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL frm_one_byte got ovf %b want 0", overflow);
    end
    do_read();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_data, rx_ready, framing_err, overflow} !== {8'h55, 3'b100}) begin
      errors++;
      $display("FAIL frm_next got %h/%b%b%b want 55/100",
               rx_data, rx_ready, framing_err, overflow);
    end
    do_read();
    wait_bits(1);
  endtask

  task automatic test_overflow();
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    wait_bits(1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_data, rx_ready, overflow} !== {8'h11, 2'b11}) begin
      errors++;
      $display("FAIL ovf_set got %h/%b%b want 11/11",
               rx_data, rx_ready, overflow);
    end
    do_read();
    checks++;
    if ({rx_ready, overflow} !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clr got %b want 00", {rx_ready, overflow});
    end
    wait_bits(1);
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
    wait_bits(1);
    send_frame(8'h66, 8, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_bits(1);
    end
    rx = 1'b1;
    repeat (BITCLK / 2) @(negedge clk);
    aresetn = 1'b0;
    #1;
    checks++;
    if ({rx_data, rx_ready, parity_err, framing_err, overflow} !==
        {8'h00, 4'b0000}) begin
      errors++;
      $display("FAIL mid_rst got %h/%b want 00/0000", rx_data,
               {rx_ready, parity_err, framing_err, overflow});
    end
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    wait_bits(5);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_partial got %b want 0", rx_ready);
    end
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({rx_data, rx_ready, framing_err, overflow} !== {8'h0F, 3'b100}) begin
      errors++;
      $display("FAIL mid_next got %h/%b%b%b want 0f/100",
               rx_data, rx_ready, framing_err, overflow);
    end
    do_read();
  endtask

  initial begin
    aresetn = 1'b1;
    rx = 1'b1;
    bit8 = 1'b1;
    parity_en = 1'b0;
    odd_n_even = 1'b0;
    rx_read = 1'b0;
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity();
    test_glitch();
    test_framing();
    test_overflow();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_async.md
UART_RX_ASYNC -- requirements
Module: uart_rx_async

Interface
REQ-001 SHALL have parameter OSR, default 16: baud_tick pulses per bit period (power of two, 8..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on rx.
REQ-003 SHALL have port clk, input, 1: system clock, all logic on rising edge.
REQ-004 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port baud_tick, input, 1: one-clk pulse at OSR x baud rate.
REQ-006 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-007 SHALL have port bit8, input, 1: 1 = 8 data bits, 0 = 7 data bits.
REQ-008 SHALL have port parity_en, input, 1: parity bit present after data.
REQ-009 SHALL have port odd_n_even, input, 1: 1 = odd parity, 0 = even parity.
REQ-010 SHALL have port rx_read, input, 1: one-clk pulse that consumes rx_data.
REQ-011 SHALL have port rx_data, output, 8: last received byte, LSB first on line; bit 7 = 0 in 7-bit mode.
REQ-012 SHALL have port rx_ready, output, 1: unread byte held in rx_data.
REQ-013 SHALL have ports parity_err, framing_err, output, 1 each: status of the byte in rx_data.
REQ-014 SHALL have port overflow, output, 1: sticky flag, byte completed while rx_ready = 1.

Function
REQ-015 SHALL pass rx through SYNC_STAGES flops (reset value 1) before any use; only the synchronized value rx_s is sampled.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK; tick counter and bit counter advance only on baud_tick.
REQ-017 IDLE: on a baud_tick with rx_s = 0 -> START, tick counter cleared.
REQ-018 START: at tick OSR/2-1 re-sample; rx_s = 1 -> IDLE (glitch rejected, no flags); rx_s = 0 -> DATA, counter cleared.
REQ-019 DATA: sample rx_s every OSR ticks at mid-bit into shift register LSB first; after 8 (bit8 = 1) or 7 (bit8 = 0) samples -> PARITY if parity_en, else STOP.
REQ-020 PARITY: sample one bit at mid-bit; parity error = XOR(data bits, parity bit, odd_n_even) = 1 (odd: total ones odd is correct) -> STOP.
REQ-021 STOP: sample at mid-bit; on that clk load rx_data, set rx_ready, update parity_err and framing_err (framing_err = ~rx_s); rx_s = 1 -> IDLE, rx_s = 0 -> BREAK.
REQ-022 BREAK: wait until a baud_tick with rx_s = 1, then -> IDLE; no byte produced.
REQ-023 Completion while rx_ready = 1 and no rx_read SHALL set overflow and leave rx_data, parity_err, framing_err unchanged (new byte dropped).
REQ-024 rx_read SHALL clear rx_ready and overflow next clk; rx_read with rx_ready = 0 has no effect.
REQ-025 rx_read and completion in the same clk: new byte loaded, rx_ready stays 1, overflow not set.
REQ-026 Changes of bit8, parity_en, odd_n_even mid-frame are undefined; sampled live, no latching required.

Reset
REQ-027 On aresetn low: state IDLE, counters 0, synchronizer 1, rx_data 0, rx_ready 0, parity_err 0, framing_err 0, overflow 0.
REQ-028 Reset mid-frame SHALL abort the frame; partial data never appears on rx_data.

Configuration
REQ-029 Macro UART_RX_PARITY_EN defined: PARITY state and parity checking as REQ-019/020.
REQ-030 Macro UART_RX_PARITY_EN undefined: parity_en and odd_n_even ignored, no PARITY state, DATA -> STOP always, parity_err constant 0.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state enumeration typedef, default OSR constant and mid-sample index constant; shared with the transmitter.
REQ-032 The synchronizer SHALL be sub-module uart_rx_sync (parameter SYNC_STAGES, reset value 1); everything else in uart_rx_async.

Verification
REQ-033 8N1, byte 0xA5 at OSR = 16 -> rx_data = 0xA5, rx_ready = 1, all error flags 0.
REQ-034 7E1 (bit8 = 0, parity_en = 1, odd_n_even = 0), byte 0x41 with wrong parity bit 1 -> rx_data = 0x41, parity_err = 1.
REQ-035 rx low for 5 ticks then high -> returns to IDLE, rx_ready stays 0.
REQ-036 8N1 byte 0x3C with stop bit 0, line held low 30 bits -> framing_err = 1, exactly one byte, next 0x55 received cleanly after line high.
REQ-037 Two bytes 0x11 then 0x22 without rx_read -> rx_data = 0x11, overflow = 1; rx_read -> rx_ready = 0, overflow = 0.
REQ-038 aresetn pulsed during bit 4 of 0xFF -> all outputs reset values, next byte 0x0F received correctly.
